// File: rtl/exec_div_unit.sv
// exec_div_unit: RV32M DIV/DIVU/REM/REMU on a 32-step restoring divider.
// Holds register-read with stall and emits a one-cycle result pulse.
module exec_div_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            inValid,
  input  logic            inIsDiv,
  input  logic            inSigned,
  input  logic            inRem,
  input  logic [31:0]     inPc,
  input  logic [XLEN-1:0] inSrc1,
  input  logic [XLEN-1:0] inSrc2,
  input  logic            flush,
  output logic            stall,
  output logic            outValid,
  output logic [31:0]     outPc,
  output logic [XLEN-1:0] outResult
);

  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] LAST = CW'(XLEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state;
  state_t nxt;

  logic [CW-1:0]   cnt;
  logic [31:0]     pc_q;
  logic            rem_op;
  logic            qneg;
  logic            rneg;
  logic [XLEN-1:0] dvs;
  logic [XLEN-1:0] q;
  logic [XLEN-1:0] r;

  logic            accept;
  logic            by_zero;
  logic            ovf;
  logic [XLEN-1:0] min_int;
  logic [XLEN-1:0] all_ones;
  logic [XLEN-1:0] a_mag;
  logic [XLEN-1:0] b_mag;
  logic [XLEN-1:0] spec_res;

  logic [XLEN:0]   r_sh;
  logic [XLEN:0]   r_diff;
  logic            ge;
  logic [XLEN-1:0] q_n;
  logic [XLEN-1:0] r_n;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] fix_res;

  logic            load_out;
  logic [XLEN-1:0] out_d;
  logic [31:0]     pc_d;

  assign min_int  = {1'b1, {(XLEN-1){1'b0}}};
  assign all_ones = '1;

  assign accept  = (state == IDLE) & inValid & inIsDiv & ~flush;
  assign by_zero = (inSrc2 == '0);
  assign ovf     = inSigned & (inSrc1 == min_int) & (inSrc2 == all_ones);

  assign a_mag = (inSigned & inSrc1[XLEN-1]) ? -inSrc1 : inSrc1;
  assign b_mag = (inSigned & inSrc2[XLEN-1]) ? -inSrc2 : inSrc2;

  assign spec_res = by_zero ? (inRem ? inSrc1 : all_ones)
                            : (inRem ? '0 : min_int);

  // borrow out of the 33-bit subtract decides the quotient bit
  assign r_sh   = {r, q[XLEN-1]};
  assign r_diff = r_sh - {1'b0, dvs};
  assign ge     = ~r_diff[XLEN];
  assign q_n    = {q[XLEN-2:0], ge};
  assign r_n    = ge ? r_diff[XLEN-1:0] : r_sh[XLEN-1:0];

  assign quo_fix = qneg ? -q_n : q_n;
  assign rem_fix = rneg ? -r_n : r_n;
  assign fix_res = rem_op ? rem_fix : quo_fix;

  always_comb begin
    nxt      = state;
    load_out = 1'b0;
    out_d    = fix_res;
    pc_d     = pc_q;
    case (state)
      IDLE: begin
        if (accept) begin
          if (by_zero | ovf) begin
            nxt      = DONE;
            load_out = 1'b1;
            out_d    = spec_res;
            pc_d     = inPc;
          end else begin
            nxt = RUN;
          end
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          nxt      = DONE;
          load_out = 1'b1;
        end
      end
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
    // a flushed op never reaches the result registers
    if (flush) begin
      nxt      = IDLE;
      load_out = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      cnt    <= '0;
      pc_q   <= '0;
      rem_op <= 1'b0;
      qneg   <= 1'b0;
      rneg   <= 1'b0;
      dvs    <= '0;
      q      <= '0;
      r      <= '0;
    end else if (accept) begin
      cnt    <= '0;
      pc_q   <= inPc;
      rem_op <= inRem;
      qneg   <= inSigned & (inSrc1[XLEN-1] ^ inSrc2[XLEN-1]);
      rneg   <= inSigned & inSrc1[XLEN-1];
      dvs    <= b_mag;
      q      <= a_mag;
      r      <= '0;
    end else if (state == RUN) begin
      cnt <= cnt + CW'(1);
      q   <= q_n;
      r   <= r_n;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      outPc     <= '0;
      outResult <= '0;
    end else if (load_out) begin
      outPc     <= pc_d;
      outResult <= out_d;
    end
  end

  assign outValid = (state == DONE) & ~flush;
  assign stall    = rstN & (accept | (state == RUN));

endmodule

// File: tb/tb_exec_div_unit.sv
// tb_exec_div_unit: directed and random divides checked every cycle
// against a cycle-accurate behavioural model of the divider.
module tb_exec_div_unit;

  logic        clk = 1'b0;
  logic        rstN;
  logic        inValid;
  logic        inIsDiv;
  logic        inSigned;
  logic        inRem;
  logic [31:0] inPc;
  logic [31:0] inSrc1;
  logic [31:0] inSrc2;
  logic        flush;
  logic        stall;
  logic        outValid;
  logic [31:0] outPc;
  logic [31:0] outResult;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          pend  = 1'b0;
  int          due   = 0;
  logic [31:0] m_res = '0;
  logic [31:0] m_pc  = '0;
  logic [31:0] h_res = '0;
  logic [31:0] h_pc  = '0;

  always #5 clk = ~clk;

  exec_div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rstN      (rstN),
    .inValid   (inValid),
    .inIsDiv   (inIsDiv),
    .inSigned  (inSigned),
    .inRem     (inRem),
    .inPc      (inPc),
    .inSrc1    (inSrc1),
    .inSrc2    (inSrc2),
    .flush     (flush),
    .stall     (stall),
    .outValid  (outValid),
    .outPc     (outPc),
    .outResult (outResult)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] ref_div(input bit s, input bit r,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int sa;
    int sb;
    if (b == 32'd0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return r ? 32'd0 : 32'h8000_0000;
    if (s) begin
      sa = a;
      sb = b;
      return r ? 32'(sa % sb) : 32'(sa / sb);
    end
    return r ? a % b : a / b;
  endfunction

  function automatic bit is_special(input bit s, input logic [31:0] a,
                                    input logic [31:0] b);
    return (b == 32'd0) || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
  endfunction

  always @(negedge rstN) begin
    pend  = 1'b0;
    h_res = '0;
    h_pc  = '0;
  end

  // one accepted op at a time; result is due 33 cycles later (1 if special)
  always @(posedge clk) begin : model
    bit acc;
    if (rstN) begin
      acc = !pend && inValid && inIsDiv && !flush;
      if (flush) pend = 1'b0;
      else if (pend && cyc == due) pend = 1'b0;
      if (acc) begin
        pend  = 1'b1;
        due   = cyc + (is_special(inSigned, inSrc1, inSrc2) ? 1 : 33);
        m_res = ref_div(inSigned, inRem, inSrc1, inSrc2);
        m_pc  = inPc;
      end
      if (pend && due == cyc + 1 && !flush) begin
        h_res = m_res;
        h_pc  = m_pc;
      end
    end
    cyc++;
  end

  always @(negedge clk) begin : compare
    bit ev;
    bit es;
    if (!rstN) begin
      chk("rst outValid", 32'(outValid), 32'd0);
      chk("rst stall", 32'(stall), 32'd0);
      chk("rst outPc", outPc, 32'd0);
      chk("rst outResult", outResult, 32'd0);
    end else begin
      ev = pend && cyc == due && !flush;
      es = (!pend && inValid && inIsDiv && !flush) || (pend && cyc < due);
      chk("outValid", 32'(outValid), 32'(ev));
      chk("stall", 32'(stall), 32'(es));
      chk("outPc", outPc, h_pc);
      chk("outResult", outResult, h_res);
    end
  end

  task automatic idle();
    inValid = 1'b0;
    inIsDiv = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // presents an op, holds it while stalled, returns just after DONE
  task automatic run_op(input bit s, input bit r, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp,
                        input int lat, input string nm,
                        output int t0, output int td);
    bit got;
    int nst;
    inValid  = 1'b1;
    inIsDiv  = 1'b1;
    inSigned = s;
    inRem    = r;
    inSrc1   = a;
    inSrc2   = b;
    inPc     = $urandom;
    t0  = cyc;
    td  = -1;
    got = 1'b0;
    nst = 0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (stall) nst++;
      if (outValid) begin
        got = 1'b1;
        td  = cyc;
        chk({nm, " result"}, outResult, exp);
        chk({nm, " latency"}, 32'(td - t0), 32'(lat));
        chk({nm, " stall cycles"}, 32'(nst), 32'(lat));
      end
    end
    chk({nm, " completed"}, 32'(got), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom % 8)
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom % 16);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int t0;
    int td;
    int t0b;
    int tdb;
    bit hold;
    rstN     = 1'b1;
    inValid  = 1'b0;
    inIsDiv  = 1'b0;
    inSigned = 1'b0;
    inRem    = 1'b0;
    inPc     = '0;
    inSrc1   = '0;
    inSrc2   = '0;
    flush    = 1'b0;
    #1 rstN = 1'b0;

    chk("pin divu 100/7", ref_div(0, 0, 32'd100, 32'd7), 32'd14);
    chk("pin rem -7/2", ref_div(1, 1, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);
    chk("pin div -7/2", ref_div(1, 0, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);

    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rstN = 1'b1;

    run_op(0, 0, 32'd100, 32'd7, 32'd14, 33, "divu 100/7", t0, td);
    idle();
    run_op(0, 1, 32'd100, 32'd7, 32'd2, 33, "remu 100/7", t0, td);
    idle();
    run_op(1, 0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, "div -7/2", t0, td);
    idle();
    run_op(1, 1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, "rem -7/2", t0, td);
    idle();
    run_op(0, 0, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFF, 33, "divu max/1", t0, td);
    idle();
    run_op(1, 0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, "div 5/0", t0, td);
    idle();
    run_op(1, 1, 32'd5, 32'd0, 32'd5, 1, "rem 5/0", t0, td);
    idle();
    run_op(1, 0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,
           "div ovf", t0, td);
    idle();
    run_op(1, 1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, "rem ovf", t0, td);
    idle();

    inValid  = 1'b1;
    inIsDiv  = 1'b1;
    inSigned = 1'b0;
    inRem    = 1'b0;
    inSrc1   = 32'd1000;
    inSrc2   = 32'd3;
    inPc     = 32'h0000_1234;
    repeat (10) begin
      @(posedge clk);
      #1;
    end
    flush   = 1'b1;
    inValid = 1'b0;
    @(negedge clk);
    chk("flush outValid", 32'(outValid), 32'd0);
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush stall drop", 32'(stall), 32'd0);
    repeat (30) idle();
    run_op(0, 0, 32'd9, 32'd3, 32'd3, 33, "divu 9/3 after flush", t0, td);
    idle();

    inValid = 1'b1;
    inIsDiv = 1'b1;
    inSrc1  = 32'd77777;
    inSrc2  = 32'd13;
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    rstN    = 1'b0;
    inValid = 1'b0;
    #1;
    chk("midrun rst outValid", 32'(outValid), 32'd0);
    chk("midrun rst stall", 32'(stall), 32'd0);
    chk("midrun rst outPc", outPc, 32'd0);
    chk("midrun rst outResult", outResult, 32'd0);
    @(posedge clk);
    #1 rstN = 1'b1;
    repeat (40) idle();
    run_op(1, 0, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 33, "div -100/7",
           t0, td);
    idle();

    run_op(0, 0, 32'd20, 32'd4, 32'd5, 33, "b2b 20/4", t0, td);
    run_op(0, 0, 32'd21, 32'd5, 32'd4, 33, "b2b 21/5", t0b, tdb);
    chk("b2b second pulse cycle", 32'(tdb - t0), 32'd67);
    idle();

    inValid = 1'b1;
    inIsDiv = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("nondiv stall", 32'(stall), 32'd0);
      @(posedge clk);
      #1;
    end
    idle();

    hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!hold) begin
        inValid  = ($urandom % 3) != 0;
        inIsDiv  = ($urandom % 4) != 0;
        inSigned = 1'($urandom % 2);
        inRem    = 1'($urandom % 2);
        inPc     = $urandom;
        inSrc1   = pick();
        inSrc2   = pick();
      end
      flush = ($urandom % 60) == 0;
      @(negedge clk);
      hold = stall && !flush;
      @(posedge clk);
      #1;
    end
    flush = 1'b0;
    repeat (40) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/exec_div_unit.md
# exec_div_unit

Consumer-side execute block on the RegRead→Execute boundary. It takes the integer operands and op class presented by the register-read stage and runs RV32M DIV/DIVU/REM/REMU on a 32-iteration restoring divider. It back-pressures the register-read stage with `stall` until the result is produced, then emits a one-cycle result pulse toward writeback.

## Interface
Parameters
- `XLEN`, default 32: operand and result width. Only 32 is supported.

Ports
- `clk` in 1: clock.
- `rstN` in 1: asynchronous, active-low reset.
- `inValid` in 1: the register-read stage's `valid`.
- `inIsDiv` in 1: the `op` decodes to the DIV/REM class.
- `inSigned` in 1: signed variant (DIV/REM).
- `inRem` in 1: return the remainder instead of the quotient.
- `inPc` in 32: instruction PC.
- `inSrc1` in 32: dividend (`srcIntRegValue1`).
- `inSrc2` in 32: divisor (`srcIntRegValue2`).
- `flush` in 1: pipeline flush. Aborts any operation in progress.
- `stall` out 1: the register-read stage must hold all outputs.
- `outValid` out 1: result pulse.
- `outPc` out 32: PC of the completed instruction.
- `outResult` out 32: quotient or remainder.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - Accept when `inValid & inIsDiv & !flush`.
  - On accept, latch `inPc`, the op flags, the operand magnitudes and the result-sign bits. Clear the 5-bit counter.
  - Divisor zero: go to DONE. Quotient = 0xFFFFFFFF, remainder = dividend.
  - Signed 0x80000000 / 0xFFFFFFFF: go to DONE. Quotient = 0x80000000, remainder = 0.
  - Otherwise go to RUN.
- **RUN**, one iteration per cycle:
  - r = {r[31:0], q[31]}. r is the 33-bit partial remainder.
  - If r ≥ {0, divisor}: r = r − divisor and q = {q[30:0], 1}. Else q = {q[30:0], 0}.
  - The counter increments each cycle. At count 31, go to DONE.
- **DONE**
  - `outValid` = 1 for exactly this cycle.
  - `outResult` holds the sign-fixed quotient or remainder.
  - Next state is always IDLE. DONE never re-accepts.
- Sign rules:
  - Quotient is negated when signed and the operand signs differ.
  - Remainder is negated when signed and the dividend is negative.
  - Magnitudes are taken by two's-complement negation. 0x80000000 maps to 0x80000000 as an unsigned value.
- `stall` = `(IDLE & inValid & inIsDiv & !flush) | RUN`. It is combinational.
  - `stall` = 0 in DONE, so the held instruction retires from register-read at the DONE edge.
- Flush:
  - In any state, `flush` forces the next state to IDLE.
  - `outValid` is masked to 0 in the flush cycle.
  - No partial result is emitted.
- Non-div instructions (`inIsDiv` = 0) are ignored. `stall` is 0 for them in IDLE.

## Timing
- Reset values (async, while `rstN` = 0):
  - state IDLE, counter 0.
  - `outValid` 0, `outPc` 0, `outResult` 0.
  - `stall` forced 0.
- Reset asserted mid-RUN aborts the operation with no output. After `rstN` rises, the unit is in IDLE.
- Normal latency: accept in IDLE at cycle 0, RUN in cycles 1–32, DONE (`outValid`) in cycle 33.
- Special-case latency (divide by zero, signed overflow): DONE in cycle 1.
- `stall` is high in cycles 0..32 (normal) or cycle 0 (special), and low in DONE.
- Back-to-back divides: the second is accepted in the cycle after DONE. Throughput is 34 cycles per normal divide.
- `outPc` and `outResult` are registered. They hold their value after DONE until the next DONE.

## Test plan
- DIVU 100 / 7: `stall` high for 33 cycles, then `outValid` at cycle 33 with `outResult` = 14. Repeating with REMU gives 2.
- DIV −7 / 2: result 0xFFFFFFFD. Repeating with REM gives 0xFFFFFFFF. DIVU 0xFFFFFFFF / 1: result 0xFFFFFFFF.
- Divide by zero:
  - DIV 5 / 0 gives 0xFFFFFFFF at cycle 1.
  - REM 5 / 0 gives 5 at cycle 1.
  - Signed 0x80000000 / 0xFFFFFFFF gives 0x80000000 at cycle 1; REM gives 0.
- Flush at RUN cycle 10: `outValid` stays 0. `stall` drops in the next cycle. The next DIVU 9 / 3 is accepted and returns 3 at +33.
- `rstN` pulsed low at RUN cycle 20: all outputs are 0 immediately. After release, no `outValid` appears, and a new divide completes normally.
- Two back-to-back DIVUs (20 / 4, then 21 / 5): `outValid` pulses at cycles 33 and 67 with results 5 and 4. A non-div `inValid` in IDLE never raises `stall`.
